// File: rtl/zion_riscv_isa_lib_add_sub_pipe.sv
// Pipelined add/sub/compare unit: the carry chain is cut into STAGES segments, one
// segment added per register stage, with valid/ready handshakes and a synchronous flush.
module zion_riscv_isa_lib_add_sub_pipe #(
    parameter int unsigned RV64   = 0,
    parameter int unsigned STAGES = 1,
    localparam int unsigned XLEN  = (RV64 != 0) ? 64 : 32
) (
    input  logic            clk,
    input  logic            rstN,
    input  logic            iFlush,
    input  logic            iValid,
    output logic            oReady,
    input  logic [3:0]      iOp,
    input  logic [XLEN-1:0] iS1,
    input  logic [XLEN-1:0] iS2,
    output logic            oValid,
    input  logic            iReady,
    output logic [XLEN-1:0] oRslt,
    output logic            oLessThan,
    output logic            oOpErr
);
    localparam int unsigned SEG = XLEN / STAGES;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] sum;
        logic            cy;
        logic            sub;
        logic            w;
        logic            uns;
        logic            err;
        logic            s1m;
        logic            s2m;
    } stage_t;

    logic              adv;
    stage_t            pre;
    stage_t            st_in  [STAGES];
    stage_t            st_out [STAGES];
    logic [STAGES-1:0] vld_q, vld_d;
    logic [XLEN-1:0]   rslt_q, rslt_d;
    logic              lt_q, lt_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   fin_rslt;
    logic              fin_lt;

    assign adv       = !vld_q[STAGES-1] || iReady;
    assign oReady    = adv;
    assign oValid    = vld_q[STAGES-1];
    assign oRslt     = rslt_q;
    assign oLessThan = lt_q;
    assign oOpErr    = err_q;

    // Sub wins when both op bits are set; neither bit zeroes both operands.
    always_comb begin : p_pre
        pre     = '0;
        pre.sub = iOp[1];
        pre.a   = (iOp[0] || iOp[1]) ? iS1 : '0;
        pre.b   = iOp[1] ? ~iS2 : (iOp[0] ? iS2 : '0);
        pre.cy  = iOp[1];
        pre.w   = (RV64 != 0) && iOp[2];
        pre.uns = iOp[3];
        pre.err = iOp[0] && iOp[1];
        pre.s1m = iS1[XLEN-1];
        pre.s2m = iS2[XLEN-1];
    end

    always_comb begin : p_seg
        logic [SEG:0] seg_sum;
        seg_sum = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            seg_sum = {1'b0, st_in[k].a[k*SEG +: SEG]} + {1'b0, st_in[k].b[k*SEG +: SEG]}
                    + {{SEG{1'b0}}, st_in[k].cy};
            st_out[k]                    = st_in[k];
            st_out[k].sum[k*SEG +: SEG]  = seg_sum[SEG-1:0];
            st_out[k].cy                 = seg_sum[SEG];
        end
    end

    always_comb begin : p_fin
        fin_rslt = st_out[STAGES-1].w ? XLEN'($signed(st_out[STAGES-1].sum[31:0]))
                                      : st_out[STAGES-1].sum;
        fin_lt   = st_out[STAGES-1].sub &&
                   ((st_out[STAGES-1].s1m ^ st_out[STAGES-1].s2m)
                        ? (st_out[STAGES-1].uns ? st_out[STAGES-1].s2m : st_out[STAGES-1].s1m)
                        : st_out[STAGES-1].sum[XLEN-1]);
    end

    // The last stage register is the output register; flush overrides any shift.
    always_comb begin : p_ctl
        vld_d  = vld_q;
        rslt_d = rslt_q;
        lt_d   = lt_q;
        err_d  = err_q;
        if (adv) begin
            vld_d[0] = iValid;
            for (int unsigned k = 1; k < STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
            end
            rslt_d = fin_rslt;
            lt_d   = fin_lt;
            err_d  = st_out[STAGES-1].err;
        end
        if (iFlush) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            vld_q  <= '0;
            rslt_q <= '0;
            lt_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            rslt_q <= rslt_d;
            lt_q   <= lt_d;
            err_q  <= err_d;
        end
    end

    if (STAGES > 1) begin : g_pipe
        stage_t pipe_q [STAGES-1];
        stage_t pipe_d [STAGES-1];

        always_comb begin : p_in
            st_in[0] = pre;
            for (int unsigned k = 1; k < STAGES; k++) begin
                st_in[k] = pipe_q[k-1];
            end
        end

        always_comb begin : p_hold
            for (int unsigned k = 0; k < STAGES - 1; k++) begin
                pipe_d[k] = adv ? st_out[k] : pipe_q[k];
            end
        end

        always_ff @(posedge clk) begin
            for (int unsigned k = 0; k < STAGES - 1; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end else begin : g_flat
        always_comb begin : p_in
            st_in[0] = pre;
        end
    end

endmodule

// File: tb/tb_zion_riscv_isa_lib_add_sub_pipe.sv
// Directed bench for the add/sub pipe: a 64-bit 4-stage instance and a 32-bit 1-stage instance.
module tb_zion_riscv_isa_lib_add_sub_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rstN;

    logic        f64, iv64, ordy64, ov64, ir64, lt64, er64;
    logic [3:0]  op64;
    logic [63:0] s1_64, s2_64, r64;
    logic        f32, iv32, ordy32, ov32, ir32, lt32, er32;
    logic [3:0]  op32;
    logic [31:0] s1_32, s2_32, r32;

    zion_riscv_isa_lib_add_sub_pipe #(.RV64(1), .STAGES(4)) u_d64 (
        .clk(clk), .rstN(rstN), .iFlush(f64), .iValid(iv64), .oReady(ordy64), .iOp(op64),
        .iS1(s1_64), .iS2(s2_64), .oValid(ov64), .iReady(ir64), .oRslt(r64),
        .oLessThan(lt64), .oOpErr(er64));

    zion_riscv_isa_lib_add_sub_pipe #(.RV64(0), .STAGES(1)) u_d32 (
        .clk(clk), .rstN(rstN), .iFlush(f32), .iValid(iv32), .oReady(ordy32), .iOp(op32),
        .iS1(s1_32), .iS2(s2_32), .oValid(ov32), .iReady(ir32), .oRslt(r32),
        .oLessThan(lt32), .oOpErr(er32));

    typedef struct packed {
        logic [63:0] r;
        logic        lt;
        logic        err;
    } res_t;

    typedef struct {
        bit          w64;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        logic        lt;
        bit          chk_lt;
        logic        err;
    } vec_t;

    vec_t vt[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic addv(input bit w, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] r, input logic lt,
                        input bit cl, input logic err);
        vec_t v;
        v.w64 = w; v.op = op; v.a = a; v.b = b; v.r = r; v.lt = lt; v.chk_lt = cl; v.err = err;
        vt.push_back(v);
    endtask

    function automatic res_t model64(input logic [3:0] op, input logic [63:0] a,
                                     input logic [63:0] b);
        res_t m;
        m.err = op[0] & op[1];
        if (op[1])      m.r = a - b;
        else if (op[0]) m.r = a + b;
        else            m.r = '0;
        if (op[2]) m.r = {{32{m.r[31]}}, m.r[31:0]};
        m.lt = op[1] & (op[3] ? (a < b) : ($signed(a) < $signed(b)));
        return m;
    endfunction

    task automatic run_op(input bit w64, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, output res_t res, output int lat);
        @(negedge clk);
        if (w64) begin
            op64 = op; s1_64 = a; s2_64 = b; iv64 = 1'b1; ir64 = 1'b1;
        end else begin
            op32 = op; s1_32 = a[31:0]; s2_32 = b[31:0]; iv32 = 1'b1; ir32 = 1'b1;
        end
        @(negedge clk);
        iv64 = 1'b0;
        iv32 = 1'b0;
        lat = 1;
        while (!(w64 ? ov64 : ov32) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res.r   = w64 ? r64 : {32'h0, r32};
        res.lt  = w64 ? lt64 : lt32;
        res.err = w64 ? er64 : er32;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        res_t        res;
        res_t        exp_q[$];
        res_t        e;
        int          lat;
        int          nv;
        int          cnt;
        logic [3:0]  s_op [16];
        logic [63:0] s_a  [16];
        logic [63:0] s_b  [16];
        int          sent;
        int          got;

        addv(1, 4'b0001, 64'h0000_0000_FFFF_FFFF, 64'h1, 64'h0000_0001_0000_0000, 0, 0, 0);
        addv(1, 4'b1110, 64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0);
        addv(1, 4'b0011, 64'h5, 64'h3, 64'h2, 0, 1, 1);
        addv(1, 4'b0000, 64'h8000_0000_0000_0000, 64'h1, 64'h0, 0, 1, 0);
        addv(1, 4'b0010, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0);
        addv(1, 4'b1010, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 0, 1, 0);
        addv(1, 4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 0, 0, 0);
        addv(1, 4'b0101, 64'h0000_0000_7FFF_FFFF, 64'h1, 64'hFFFF_FFFF_8000_0000, 0, 0, 0);
        addv(1, 4'b0110, 64'h0000_0001_0000_0005, 64'h3, 64'h2, 0, 1, 0);
        addv(1, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0);
        addv(1, 4'b0010, 64'h0001_0000_0000_0000, 64'h1, 64'h0000_FFFF_FFFF_FFFF, 0, 1, 0);
        addv(1, 4'b0001, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 0, 0, 0);
        addv(1, 4'b0110, 64'h1, 64'h0000_0001_0000_0000, 64'h1, 1, 1, 0);
        addv(1, 4'b1010, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1, 1, 0);
        addv(0, 4'b0010, 64'h8000_0000, 64'h1, 64'h7FFF_FFFF, 1, 1, 0);
        addv(0, 4'b1010, 64'h8000_0000, 64'h1, 64'h7FFF_FFFF, 0, 1, 0);
        addv(0, 4'b0001, 64'hFFFF_FFFF, 64'h1, 64'h0, 0, 0, 0);
        addv(0, 4'b0110, 64'h0, 64'h1, 64'hFFFF_FFFF, 1, 1, 0);
        addv(0, 4'b0011, 64'h5, 64'h3, 64'h2, 0, 1, 1);
        addv(0, 4'b0000, 64'h8000_0000, 64'h1, 64'h0, 0, 1, 0);

        rstN = 1'b0;
        f64 = 0; iv64 = 0; ir64 = 1; op64 = '0; s1_64 = '0; s2_64 = '0;
        f32 = 0; iv32 = 0; ir32 = 1; op32 = '0; s1_32 = '0; s2_32 = '0;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        chk("reset.ov64", 64'(ov64), 64'd0);
        chk("reset.rslt64", r64, 64'h0);
        chk("reset.lt64", 64'(lt64), 64'd0);
        chk("reset.err64", 64'(er64), 64'd0);
        chk("reset.ordy64", 64'(ordy64), 64'd1);
        chk("reset.ov32", 64'(ov32), 64'd0);
        chk("reset.ordy32", 64'(ordy32), 64'd1);

        for (int i = 0; i < vt.size(); i++) begin
            run_op(vt[i].w64, vt[i].op, vt[i].a, vt[i].b, res, lat);
            chk($sformatf("vec%0d.latency", i), 64'(lat), vt[i].w64 ? 64'd4 : 64'd1);
            chk($sformatf("vec%0d.rslt", i), res.r, vt[i].r);
            chk($sformatf("vec%0d.operr", i), 64'(res.err), 64'(vt[i].err));
            if (vt[i].chk_lt) chk($sformatf("vec%0d.lt", i), 64'(res.lt), 64'(vt[i].lt));
        end

        // Stall: result held stable and oReady low while the consumer is not ready.
        @(negedge clk);
        op64 = 4'b0001; s1_64 = 64'h10; s2_64 = 64'h20; iv64 = 1; ir64 = 0;
        @(negedge clk);
        iv64 = 0;
        cnt = 0;
        while (!ov64 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall%0d.valid", i), 64'(ov64), 64'd1);
            chk($sformatf("stall%0d.rslt", i), r64, 64'h30);
            chk($sformatf("stall%0d.ordy", i), 64'(ordy64), 64'd0);
            @(negedge clk);
        end
        ir64 = 1;
        @(negedge clk);
        chk("stall.retire_once", 64'(ov64), 64'd0);

        // Flush with three ops in flight and a fourth presented alongside the flush.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op64 = 4'b0001; s1_64 = 64'(i); s2_64 = 64'd100; iv64 = 1;
        end
        @(negedge clk);
        f64 = 1; s1_64 = 64'd99;
        @(negedge clk);
        f64 = 0; iv64 = 0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            nv += int'(ov64);
            @(negedge clk);
        end
        chk("flush.no_valid", 64'(nv), 64'd0);
        run_op(1, 4'b0001, 64'd7, 64'd8, res, lat);
        chk("flush.next_latency", 64'(lat), 64'd4);
        chk("flush.next_rslt", res.r, 64'd15);

        // Random stream with iReady toggling every three cycles.
        for (int i = 0; i < 16; i++) begin
            s_op[i] = 4'($urandom_range(0, 15));
            s_a[i]  = {$urandom, $urandom};
            s_b[i]  = {$urandom, $urandom};
        end
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
            @(negedge clk);
            ir64 = ((cyc / 3) % 2) == 0;
            if (sent < 16) begin
                iv64 = 1; op64 = s_op[sent]; s1_64 = s_a[sent]; s2_64 = s_b[sent];
            end else begin
                iv64 = 0;
            end
            #1;
            if (ov64 && ir64) begin
                if (exp_q.size() == 0) begin
                    chk("stream.spurious", 64'(ov64), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("stream%0d.rslt", got), r64, e.r);
                    chk($sformatf("stream%0d.operr", got), 64'(er64), 64'(e.err));
                    if (s_op[got][1]) chk($sformatf("stream%0d.lt", got), 64'(lt64), 64'(e.lt));
                end
                got++;
            end
            if (iv64 && ordy64) begin
                exp_q.push_back(model64(s_op[sent], s_a[sent], s_b[sent]));
                sent++;
            end
        end
        chk("stream.count", 64'(got), 64'd16);
        chk("stream.leftover", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        iv64 = 0; ir64 = 1;
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nv += int'(ov64);
        end
        chk("stream.no_duplicates", 64'(nv), 64'd0);

        // Reset asserted with operations in flight and a new input presented.
        @(negedge clk);
        op64 = 4'b0010; s1_64 = 64'd50; s2_64 = 64'd20; iv64 = 1;
        @(negedge clk);
        @(negedge clk);
        rstN = 0;
        @(negedge clk);
        rstN = 1; iv64 = 0;
        chk("midreset.ov64", 64'(ov64), 64'd0);
        chk("midreset.rslt64", r64, 64'h0);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            nv += int'(ov64);
        end
        chk("midreset.no_valid", 64'(nv), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zion_riscv_isa_lib_add_sub_pipe.md
# zion_riscv_isa_lib_add_sub_pipe

Pipelined, parametrised integer add/subtract/compare unit for the EX stage of Zion RISC-V cores. It executes ADD/ADDI, SUB, ADDW/ADDIW, SUBW, and signed/unsigned less-than (SLT[I][U], BLT[U], BGE[U]). The carry chain is split across `STAGES` register stages so wide datapaths close timing. Operands enter and results leave through valid/ready handshakes, with a synchronous flush for pipeline kills.

## Interface
- `RV64`, 0: 1 = 64-bit datapath (XLEN = 64), 0 = 32-bit (XLEN = 32).
- `STAGES`, 1: pipeline depth and carry-chain segment count, one of {1, 2, 4}. Segment width SEG = XLEN/STAGES.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  clock, all state on rising edge.
- `rstN`  in  1  synchronous active-low reset.
- `iFlush`  in  1  kill all in-flight operations.
- `iValid`  in  1  input operation valid.
- `oReady`  out  1  unit can accept an input this cycle.
- `iOp`  in  4  [0] add, [1] sub, [2] .W (ignored when RV64 = 0), [3] unsigned compare.
- `iS1`, `iS2`  in  XLEN  operands.
- `oValid`  out  1  result valid.
- `iReady`  in  1  consumer accepts the result.
- `oRslt`  out  XLEN  sum or difference.
- `oLessThan`  out  1  iS1 < iS2 (signed or unsigned per iOp[3]), valid only for sub.
- `oOpErr`  out  1  add and sub were both set for this operation.

## Operation
- Operand pre-processing happens at input:
  - add: B = iS2, cin = 0.
  - sub: B = ~iS2, cin = 1.
  - add and sub both set: treated as sub, and oOpErr = 1 travels with the operation.
  - neither set: A = 0, B = 0, cin = 0, so oRslt = 0 and oLessThan = 0.
- Stage k (0..STAGES-1) adds segment k of A and B plus the carry registered from stage k-1 (cin for stage 0).
  - Lower result segments and the upper operand segments not yet added are delayed alongside.
  - The carry out of the top segment is discarded.
- .W (RV64 only):
  - oRslt = sign-extension of result bits [31:0].
  - oLessThan is still computed on the full XLEN (no W compare exists).
- Less-than, with s1m = iS1[XLEN-1], s2m = iS2[XLEN-1], dm = difference[XLEN-1]:
  - signed: (s1m ^ s2m) ? s1m : dm.
  - unsigned: (s1m ^ s2m) ? s2m : dm.
  - Only the MSBs of iS1/iS2 are carried down the pipe for this.
- Handshake:
  - adv = !oValid || iReady, and oReady = adv. This is a combinational path from iReady to oReady.
  - When adv = 1, every stage's valid, data and carry shift forward by one. Stage 0 loads (iValid && oReady).
  - When adv = 0, all stages hold.
- Flush: iFlush = 1 clears every stage-valid and oValid at the next edge, and the input in that cycle is dropped. Flush has priority over adv.
- Reset: all stage-valids = 0. oValid = 0, oRslt = 0, oLessThan = 0, oOpErr = 0. oReady = 1 in the first cycle after reset release.
- Data registers are reset only on the output stage; internal data registers need no reset.

## Timing
- Latency: an input accepted at edge t produces oValid = 1 after edge t+STAGES-1 when no stall occurs. For STAGES = 1, the result is registered and visible in the cycle after acceptance.
- Throughput: one operation per cycle while iReady = 1.
- Stall: outputs stay stable while oValid && !iReady. No operation is lost or duplicated.
- Bubbles advance through the pipe the same way as valid entries. A stall blocks the whole pipe, including bubbles.
- Simultaneous flush and accept: flush wins, and nothing is loaded.
- Simultaneous iReady and a new input with a full pipe: the output retires and the input enters in the same edge.
- Reset asserted mid-operation: the pipe is empty on the next edge, regardless of iValid, iReady or iFlush.

## Test plan
- RV64 = 1, STAGES = 4, add 0x0000_0000_FFFF_FFFF + 1 → oRslt = 0x0000_0001_0000_0000 exactly 4 cycles after accept; the carry crosses segments.
- RV64 = 1, sub+.W, iS1 = 0, iS2 = 1 → oRslt = 0xFFFF_FFFF_FFFF_FFFF. Unsigned compare 0 < 1 gives oLessThan = 1.
- RV64 = 0, sub: signed 0x8000_0000 vs 0x0000_0001 → oLessThan = 1. The same operands unsigned → oLessThan = 0.
- Back-to-back stream of 16 random ops with iReady toggling every 3 cycles → results match a reference model in order, with no drops or duplicates.
- Three ops in flight, iFlush pulsed for one cycle while iValid = 1 → no oValid is produced for any of them. The next accepted op returns normally.
- iOp = 4'b0011 with iS1 = 5, iS2 = 3 → oRslt = 2, oOpErr = 1. iOp = 0 → oRslt = 0, oLessThan = 0.
